// File: rtl/hilo_ctrl.sv
// HI/LO issue-and-retire controller for the iterative multiply/divide unit.
// Optional divide-by-zero bypass is compiled in with HILO_DIV0_BYPASS_EN.
module hilo_ctrl #(
   parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_rs,
   input  logic [31:0] req_rt,
   output logic        req_ready,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        div0,
   output logic        md_enable,
   output logic [1:0]  md_operation,
   output logic [31:0] md_value_1,
   output logic [31:0] md_value_2,
   input  logic [63:0] md_out,
   input  logic        md_in_operation
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        rd_valid_q;
   logic [31:0] rd_data_q;
   logic        div0_q;
   logic        md_enable_q;
   logic [1:0]  md_operation_q;
   logic [31:0] md_value_1_q;
   logic [31:0] md_value_2_q;
   logic        div0_hit_s;

   // A zero divisor on DIV/DIVU is resolved locally only when the bypass is built in.
`ifdef HILO_DIV0_BYPASS_EN
   assign div0_hit_s = req_op[1] & ~req_op[2] & (req_rt == 32'd0);
`else
   assign div0_hit_s = 1'b0;
`endif

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   // Controller FSM, HI/LO architectural state and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         hi_q           <= 32'd0;
         lo_q           <= 32'd0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= 32'd0;
         div0_q         <= 1'b0;
         md_enable_q    <= 1'b0;
         md_operation_q <= 2'd0;
         md_value_1_q   <= 32'd0;
         md_value_2_q   <= 32'd0;
      end else begin
         rd_valid_q  <= 1'b0;
         div0_q      <= 1'b0;
         md_enable_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  case (req_op)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        if (div0_hit_s) begin
                           hi_q   <= req_rs;
                           lo_q   <= DIV0_LO;
                           div0_q <= 1'b1;
                        end else begin
                           md_value_1_q   <= req_rs;
                           md_value_2_q   <= req_rt;
                           md_operation_q <= req_op[1:0];
                           md_enable_q    <= 1'b1;
                           state_q        <= ISSUE;
                        end
                     end
                     3'd4: hi_q <= req_rs;
                     3'd5: lo_q <= req_rs;
                     3'd6: begin
                        rd_data_q  <= hi_q;
                        rd_valid_q <= 1'b1;
                     end
                     3'd7: begin
                        rd_data_q  <= lo_q;
                        rd_valid_q <= 1'b1;
                     end
                     default: state_q <= IDLE;
                  endcase
               end
            end
            // The unit raises its busy flag only after sampling enable, so ISSUE never looks at it.
            ISSUE: state_q <= WAIT;
            WAIT: begin
               if (!md_in_operation) begin
                  hi_q    <= md_out[63:32];
                  lo_q    <= md_out[31:0];
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;
   assign div0         = div0_q;
   assign md_enable    = md_enable_q;
   assign md_operation = md_operation_q;
   assign md_value_1   = md_value_1_q;
   assign md_value_2   = md_value_2_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl with a behavioural multiply/divide unit model.
module tb_hilo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_rs = 32'd0;
   logic [31:0] req_rt = 32'd0;
   logic        req_ready, rd_valid, busy, div0, md_enable, md_in_operation;
   logic [31:0] rd_data, md_value_1, md_value_2;
   logic [1:0]  md_operation;
   logic [63:0] md_out;

   int pass_cnt = 0;
   int chk_cnt = 0;
   logic [31:0] exp_q[$];

   hilo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_rs(req_rs), .req_rt(req_rt), .req_ready(req_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .div0(div0),
      .md_enable(md_enable), .md_operation(md_operation),
      .md_value_1(md_value_1), .md_value_2(md_value_2),
      .md_out(md_out), .md_in_operation(md_in_operation)
   );

   always #5 clk = ~clk;

   // Unit model: not reset by rst_n, enable restarts it; busy 1 cycle for mult, 34 for div.
   int          unit_cnt = 0;
   logic [63:0] unit_out = 64'd0;

   function automatic logic [63:0] unit_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      int sa, sb, q, r;
      case (op)
         2'd0: return {32'd0, a} * {32'd0, b};
         2'd1: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         2'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            sa = $signed(a); sb = $signed(b);
            q = sa / sb; r = sa % sb;
            return {32'(r), 32'(q)};
         end
      endcase
   endfunction

   always @(posedge clk) begin
      if (md_enable) begin
         unit_cnt <= md_operation[1] ? 34 : 1;
         unit_out <= unit_calc(md_operation, md_value_1, md_value_2);
      end else if (unit_cnt > 0) begin
         unit_cnt <= unit_cnt - 1;
      end
   end
   assign md_in_operation = (unit_cnt != 0);
   assign md_out = unit_out;

   // Presents a request and returns at the negedge after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
      n = 0;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      chk_cnt++;
      if (n >= 200) $display("FAIL accept_timeout op=%0d got ready=%b required 1", op, req_ready);
      else pass_cnt++;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(output int edges);
      int n;
      n = 0;
      while (busy && n < 200) begin @(negedge clk); n++; end
      edges = n;
      chk_cnt++;
      if (n >= 200) $display("FAIL idle_timeout got busy=%b required 0", busy);
      else pass_cnt++;
   endtask

   task automatic read_reg(input logic [2:0] op, input logic [31:0] expv, input string name);
      logic [31:0] e;
      exp_q.push_back(expv);
      send(op, 32'd0, 32'd0);
      e = exp_q.pop_front();
      chk_cnt++;
      if (rd_valid !== 1'b1) $display("FAIL %s_valid got %b required 1", name, rd_valid);
      else pass_cnt++;
      chk_cnt++;
      if (rd_data !== e) $display("FAIL %s_data got %h required %h", name, rd_data, e);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({busy, req_ready, md_enable, rd_valid, div0} !== 5'b01000)
         $display("FAIL reset_ctrl got %b required 01000", {busy, req_ready, md_enable, rd_valid, div0});
      else pass_cnt++;
      chk_cnt++;
      if ({md_operation, md_value_1, md_value_2, rd_data} !== 98'd0)
         $display("FAIL reset_data got %h required 0", {md_operation, md_value_1, md_value_2, rd_data});
      else pass_cnt++;
      rst_n = 1'b1;
      read_reg(3'd6, 32'd0, "reset_hi");
      read_reg(3'd7, 32'd0, "reset_lo");
   endtask

   task automatic test_mult();
      int n, en_cnt, low_cnt;
      send(3'd1, 32'hFFFF_FFFD, 32'd5);
      chk_cnt++;
      if ({md_operation, md_value_1, md_value_2} !== {2'd1, 32'hFFFF_FFFD, 32'd5})
         $display("FAIL mult_operands got %h required %h", {md_operation, md_value_1, md_value_2}, {2'd1, 32'hFFFF_FFFD, 32'd5});
      else pass_cnt++;
      en_cnt = md_enable ? 1 : 0;
      low_cnt = req_ready ? 0 : 1;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk); n++;
         if (md_enable) en_cnt++;
         if (!req_ready) low_cnt++;
      end
      chk_cnt++;
      if (en_cnt != 1) $display("FAIL mult_enable_cycles got %0d required 1", en_cnt);
      else pass_cnt++;
      chk_cnt++;
      if (low_cnt != 3) $display("FAIL mult_ready_low got %0d required 3", low_cnt);
      else pass_cnt++;
      chk_cnt++;
      if (n != 3) $display("FAIL mult_capture_edge got %0d required 3", n);
      else pass_cnt++;
      read_reg(3'd6, 32'hFFFF_FFFF, "mult_hi");
      read_reg(3'd7, 32'hFFFF_FFF1, "mult_lo");
   endtask

   task automatic test_divu();
      int n;
      send(3'd2, 32'd100, 32'd7);
      wait_idle(n);
      chk_cnt++;
      if (n != 36) $display("FAIL divu_capture_edge got %0d required 36", n);
      else pass_cnt++;
      read_reg(3'd7, 32'h0000_000E, "divu_lo");
   endtask

   task automatic test_div();
      int n;
      send(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      read_reg(3'd7, 32'hFFFF_FFFD, "div_lo");
      read_reg(3'd6, 32'hFFFF_FFFF, "div_hi");
   endtask

   task automatic test_back_to_back();
      int n;
      logic [31:0] e;
      send(3'd2, 32'd100, 32'd7);
      req_valid = 1'b1; req_op = 3'd6;
      exp_q.push_back(32'h0000_0002);
      n = 0;
      while (!rd_valid && n < 200) begin @(negedge clk); n++; end
      req_valid = 1'b0;
      e = exp_q.pop_front();
      chk_cnt++;
      if (n != 37) $display("FAIL b2b_mfhi_edge got %0d required 37", n);
      else pass_cnt++;
      chk_cnt++;
      if (rd_data !== e) $display("FAIL b2b_mfhi_data got %h required %h", rd_data, e);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({rd_valid, rd_data} !== {1'b0, e}) $display("FAIL b2b_pulse_hold got %h required %h", {rd_valid, rd_data}, {1'b0, e});
      else pass_cnt++;
   endtask

   task automatic test_mtlo();
      send(3'd5, 32'h1234_5678, 32'd0);
      chk_cnt++;
      if ({busy, req_ready} !== 2'b01) $display("FAIL mtlo_idle got %b required 01", {busy, req_ready});
      else pass_cnt++;
      read_reg(3'd7, 32'h1234_5678, "mtlo_lo");
   endtask

   task automatic test_reset_mid();
      int n;
      send(3'd3, 32'hFFFF_FFF9, 32'd2);
      repeat (10) @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b1) $display("FAIL midrst_busy_before got %b required 1", busy);
      else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({busy, md_enable} !== 2'b00) $display("FAIL midrst_async got %b required 00", {busy, md_enable});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      read_reg(3'd6, 32'd0, "midrst_hi");
      read_reg(3'd7, 32'd0, "midrst_lo");
      send(3'd0, 32'd6, 32'd7);
      chk_cnt++;
      if ({md_enable, md_operation} !== 3'b100) $display("FAIL multu_issue got %b required 100", {md_enable, md_operation});
      else pass_cnt++;
      wait_idle(n);
      chk_cnt++;
      if (n != 3) $display("FAIL multu_capture_edge got %0d required 3", n);
      else pass_cnt++;
      read_reg(3'd7, 32'h0000_002A, "multu_lo");
      read_reg(3'd6, 32'd0, "multu_hi");
   endtask

   task automatic test_div0();
      int n;
      send(3'd2, 32'h55, 32'd0);
`ifdef HILO_DIV0_BYPASS_EN
      chk_cnt++;
      if ({md_enable, div0, req_ready, busy} !== 4'b0110)
         $display("FAIL div0_bypass got %b required 0110", {md_enable, div0, req_ready, busy});
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (div0 !== 1'b0) $display("FAIL div0_pulse_end got %b required 0", div0);
      else pass_cnt++;
      read_reg(3'd6, 32'h0000_0055, "div0_hi");
      read_reg(3'd7, 32'hFFFF_FFFF, "div0_lo");
`else
      chk_cnt++;
      if ({md_enable, div0, busy} !== 3'b101) $display("FAIL div0_issued got %b required 101", {md_enable, div0, busy});
      else pass_cnt++;
      wait_idle(n);
      chk_cnt++;
      if (n != 36) $display("FAIL div0_capture_edge got %0d required 36", n);
      else pass_cnt++;
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mult();
      test_divu();
      test_div();
      test_back_to_back();
      test_mtlo();
      test_reset_mid();
      test_div0();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Issue and retire controller for the iterative multiply/divide unit. It owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the execute stage.
- Drives the unit's enable/operation/operand inputs, waits on its busy flag, and captures the 64-bit result into HI/LO.
- Interlocks the pipeline until the result is retired.

Parameters:
- DIV0_LO, 32'hFFFF_FFFF, value written to LO on a divide-by-zero bypass. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_op  in  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- req_rs  in  32  rs operand / MTHI-MTLO data
- req_rt  in  32  rt operand
- req_ready  out  1  request accepted on this edge when req_valid is also high; combinational, equals (state==IDLE)
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  32  HI or LO for MFHI/MFLO
- busy  out  1  state!=IDLE
- div0  out  1  one-cycle pulse on divide-by-zero bypass; tied 0 without the feature
- md_enable  out  1  one-cycle start pulse to the unit
- md_operation  out  2  req_op[1:0]
- md_value_1  out  32  latched rs
- md_value_2  out  32  latched rt
- md_out  in  64  unit result; [63:32] to HI (product high / remainder), [31:0] to LO (product low / quotient)
- md_in_operation  in  1  unit busy

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; HI=0; LO=0; md_enable=0; md_operation=0; md_value_1=0; md_value_2=0; rd_valid=0; rd_data=0; div0=0. Reset mid-operation abandons the operation; HI/LO are not updated.
- All outputs except req_ready and busy are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE, req_valid, op 0-3 (edge 0):
  - latch md_value_1=rs, md_value_2=rt, md_operation=op[1:0]
  - md_enable<=1
  - ->ISSUE
- ISSUE: unit samples enable on edge 1. md_enable<=0. ->WAIT. md_in_operation is ignored in ISSUE (the unit only asserts it after edge 1).
- WAIT: on the first edge where md_in_operation==0: HI<=md_out[63:32], LO<=md_out[31:0], ->IDLE.
- Completion depends only on md_in_operation, never on a fixed count. With current unit timing, HI/LO are written at edge 3 for multiplies and edge 36 for divides.
- IDLE, MTHI/MTLO: HI (resp. LO) <= rs at edge 0. Stays IDLE.
- IDLE, MFHI/MFLO: rd_data<=HI (resp. LO), rd_valid<=1 for one cycle. Stays IDLE.
- rd_valid and div0 return to 0 on the following edge. rd_data holds its last value.
- Busy interlock: req_ready=0 in ISSUE/WAIT for all ops. A request must be held by the requester and is accepted in the first IDLE cycle.
- A request arriving in the same cycle as WAIT capture is not accepted until the next cycle.
- After reset the unit may still report busy from an abandoned operation. The controller ignores md_in_operation in IDLE. A new enable pulse restarts the unit, because enable has priority inside it.
- Signed/unsigned handling and sign correction are done by the unit. The controller passes operands unmodified.

Optional Feature:
- Macro: HILO_DIV0_BYPASS_EN.
- Defined: DIV/DIVU with rt==0 is not issued. At edge 0: HI<=rs, LO<=DIV0_LO, div0 pulses 1 cycle, state stays IDLE, md_enable stays 0.
- Undefined: a zero divisor is issued to the unit like any divide; HI/LO take whatever the unit returns; div0 is constant 0.

Test Plan:
- MULT rs=FFFFFFFD (-3), rt=5 -> md_enable high exactly 1 cycle; HI=FFFFFFFF, LO=FFFFFFF1; req_ready low for 3 cycles after acceptance.
- DIVU rs=100, rt=7 -> HI=00000002, LO=0000000E after md_in_operation falls; then MFLO -> rd_valid pulse, rd_data=0000000E.
- DIV rs=FFFFFFF9 (-7), rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- MFHI held valid during DIVU 100/7 -> req_ready low until capture; MFHI accepted the cycle after, rd_data=00000002.
- MTLO rs=12345678 then MFLO -> rd_data=12345678. Then assert rst_n=0 during a DIV -> HI=LO=0, busy=0; next MULTU 6*7 -> LO=0000002A, HI=0.
- With HILO_DIV0_BYPASS_EN: DIVU rs=55, rt=0 -> no md_enable, div0 pulse, HI=00000055, LO=FFFFFFFF, req_ready stays 1.
